alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_iter.sv | 73 +++++++
 rtl/alu_mc.sv | 100 ++++++++++
 tb/tb_alu_mc.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and decode helpers for the multi-cycle ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_SLL  = 4'b1000,
        OP_SRL  = 4'b1001,
        OP_SRA  = 4'b1011,
        OP_MUL  = 4'b1100,
        OP_DIVU = 4'b1101,
        OP_REMU = 4'b1110
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_multi(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_iter.sv
// Iterative engine: shift-add multiply and restoring divide, one bit per cycle for WIDTH cycles.
module alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] value
);

    localparam int CW = $clog2(WIDTH);

    // acc: product accumulator / partial remainder
    // opx: shifted multiplicand / dividend-then-quotient
    // opy: shifted multiplier / divisor
    logic [WIDTH-1:0] acc, opx, opy;
    logic [3:0]       op_r;
    logic             run;
    logic [CW-1:0]    cnt;

    logic             is_div;
    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] next_acc, next_x, next_y;

    always_comb begin
        is_div   = (op_r == OP_DIVU) || (op_r == OP_REMU);
        mul_acc  = acc + (opy[0] ? opx : '0);
        rem_sh   = {acc, opx[WIDTH-1]};
        diff     = rem_sh - {1'b0, opy};
        fits     = !diff[WIDTH];
        // A zero divisor always "fits", giving all-ones quotient and remainder = a.
        next_acc = is_div ? (fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]) : mul_acc;
        next_x   = is_div ? {opx[WIDTH-2:0], fits} : (opx << 1);
        next_y   = is_div ? opy : (opy >> 1);
        done     = run && (cnt == CW'(WIDTH - 1));
        value    = (op_r == OP_DIVU) ? next_x : next_acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            opx  <= '0;
            opy  <= '0;
            op_r <= '0;
            run  <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            acc  <= '0;
            opx  <= a;
            opy  <= b;
            op_r <= op;
            run  <= 1'b1;
            cnt  <= '0;
        end else if (run) begin
            acc <= next_acc;
            opx <= next_x;
            opy <= next_y;
            cnt <= cnt + 1'b1;
            if (done)
                run <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake; single-cycle ops inline, MUL/DIVU/REMU iterated.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    state_e           state, state_nxt;
    logic             accept;
    logic             start;
    logic             iter_done;
    logic [WIDTH-1:0] iter_value;
    logic [WIDTH-1:0] alu_comb;
    logic [SHW-1:0]   sh;

    assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign start     = accept && is_multi(op);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state == ST_BUSY);
    assign sh        = b[SHW-1:0];

    always_comb begin
        alu_comb = '0;
        case (op)
            OP_AND:  alu_comb = a & b;
            OP_OR:   alu_comb = a | b;
            OP_XOR:  alu_comb = a ^ b;
            OP_ADD:  alu_comb = a + b;
            OP_SUB:  alu_comb = a - b;
            OP_SLT:  alu_comb = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL:  alu_comb = a << sh;
            OP_SRL:  alu_comb = a >> sh;
            OP_SRA:  alu_comb = $unsigned($signed(a) >>> sh);
            default: alu_comb = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = is_multi(op) ? ST_BUSY : ST_DONE;
            ST_BUSY: if (iter_done) state_nxt = ST_DONE;
            ST_DONE: begin
                if (accept)
                    state_nxt = is_multi(op) ? ST_BUSY : ST_DONE;
                else if (out_ready)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Result only moves on a single-cycle accept or iteration completion, so it holds under back-pressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
            zero   <= 1'b1;
        end else if (accept && !is_multi(op)) begin
            result <= alu_comb;
            zero   <= (alu_comb == '0);
        end else if ((state == ST_BUSY) && iter_done) begin
            result <= iter_value;
            zero   <= (iter_value == '0);
        end
    end

    alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .done  (iter_done),
        .value (iter_value)
    );

endmodule

// File: tb/tb_alu_mc.sv
// Randomized and directed bench for alu_mc against a behavioural model of the ALU rules.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int checks = 0;
    int errors = 0;

    alu_mc #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        int unsigned s;
        logic [63:0] wide;
        s = y % 32;
        case (o)
            4'b0000: return x & y;
            4'b0001: return x | y;
            4'b0011: return x ^ y;
            4'b0010: return x + y;
            4'b0110: return x - y;
            4'b0111: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'b1000: return x * (32'd1 << s);
            4'b1001: return x / (32'd1 << s);
            4'b1011: begin
                wide = {{32{x[31]}}, x};
                wide = wide >> s;
                return wide[31:0];
            end
            4'b1100: begin
                wide = {32'd0, x} * {32'd0, y};
                return wide[31:0];
            end
            4'b1101: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            4'b1110: return (y == 0) ? x : x % y;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] o);
        return (o == 4'b1100 || o == 4'b1101 || o == 4'b1110) ? 33 : 1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one op, count cycles to out_valid (cycle 1 = just after the accept edge), check everything.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit poke_busy);
        int k;
        int wait_n;
        int busy_bad;
        logic [31:0] exp_v;
        exp_v  = ref_alu(o, x, y);
        wait_n = 0;
        while (!in_ready && wait_n < 100) begin
            tick();
            wait_n++;
        end
        in_valid = 1'b1;
        op = o; a = x; b = y;
        tick();
        in_valid = 1'b0;
        op = 4'hF; a = $urandom; b = $urandom;
        k = 1;
        busy_bad = 0;
        while (!out_valid && k < 100) begin
            if (!busy) busy_bad++;
            if (poke_busy && k == 3) begin
                in_valid = 1'b1;
                op = 4'b0010;
                check({tag, "_in_ready_busy"}, {31'd0, in_ready}, 32'd0);
            end
            if (poke_busy && k == 20) in_valid = 1'b0;
            tick();
            k++;
        end
        in_valid = 1'b0;
        check({tag, "_latency"}, k, ref_latency(o));
        check({tag, "_busy_cycles"}, busy_bad, 0);
        check({tag, "_result"}, result, exp_v);
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_v == 0});
        if (out_ready) tick();
    endtask

    logic [3:0] rop;
    logic [31:0] ra, rb, held_r, exp_n;
    logic held_z;
    int stray;

    initial begin
        repeat (2) tick();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd1);
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        run_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 0);
        run_op("sub_zero", 4'b0110, 32'd5, 32'd5, 0);
        run_op("sra", 4'b1011, 32'h8000_0000, 32'h24, 0);
        run_op("srl", 4'b1001, 32'h8000_0000, 32'h24, 0);
        run_op("slt", 4'b0111, 32'hFFFF_FFFF, 32'd1, 0);
        run_op("mul", 4'b1100, 32'h0000_FFFF, 32'h0001_0001, 1);
        run_op("divu", 4'b1101, 32'd100, 32'd7, 0);
        run_op("remu", 4'b1110, 32'd100, 32'd7, 0);
        run_op("divu0", 4'b1101, 32'd9, 32'd0, 0);
        run_op("remu0", 4'b1110, 32'd9, 32'd0, 0);
        run_op("illegal", 4'b0100, 32'h1234_5678, 32'h9ABC_DEF0, 0);

        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            run_op($sformatf("rnd%0d_op%0h", i, rop), rop, ra, rb, 0);
        end

        // Back-pressure: result must hold while out_ready is low, then handoff + accept on one edge.
        out_ready = 1'b0;
        in_valid = 1'b1; op = 4'b0001; a = 32'h00F0_0000; b = 32'h0000_000F;
        tick();
        in_valid = 1'b0;
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        held_r = result;
        held_z = zero;
        check("bp_or_result", result, 32'h00F0_000F);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_result", result, held_r);
            check("bp_hold_zero", {31'd0, zero}, {31'd0, held_z});
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        in_valid = 1'b1; op = 4'b0010; a = 32'd40; b = 32'd2;
        exp_n = ref_alu(4'b0010, 32'd40, 32'd2);
        #1;
        check("bp_same_edge_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_next_valid", {31'd0, out_valid}, 32'd1);
        check("bp_next_result", result, exp_n);
        tick();

        // Reset in the middle of a DIVU discards it.
        in_valid = 1'b1; op = 4'b1101; a = 32'd1000; b = 32'd3;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_result", result, 32'd0);
        check("mid_rst_zero", {31'd0, zero}, 32'd1);
        tick();
        rst = 1'b0;
        tick();
        check("rel_in_ready", {31'd0, in_ready}, 32'd1);
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid || busy) stray++;
            tick();
        end
        check("no_stray_result", stray, 0);
        run_op("add_after_rst", 4'b0010, 32'd2, 32'd3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
